// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined MIPS control unit: opcodes, funct codes,
// ALU codes, MDU FSM states and the per-stage control bundles.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  typedef struct packed {
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mdu;
    logic [2:0] alu_ctrl;
  } id_ex_t;

  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem_to_reg;
    logic mem_read;
  } ex_mem_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } mem_wb_t;

endpackage

// File: rtl/ctrl_pipe_mdu_if.sv
// Signal bundle between the control unit and its surroundings (decoder input,
// hazard-unit requests, per-stage control outputs and the MDU state for debug).
interface ctrl_pipe_mdu_if;
  import ctrl_pkg::*;

  logic [5:0] op;
  logic [5:0] funct;
  logic [2:0] stall;
  logic [2:0] flush;
  logic       branch_d;
  logic       jump_d;
  logic [2:0] alu_ctrl_e;
  logic       alu_src_e;
  logic       reg_dst_e;
  logic       mem_read_e;
  logic       reg_write_e;
  logic       mdu_e;
  logic       reg_write_m;
  logic       mem_write_m;
  logic       mem_read_m;
  logic       mem_to_reg_m;
  logic       reg_write_w;
  logic       mem_to_reg_w;
  logic       mdu_busy;
  logic       mdu_done;
  mdu_state_t mdu_state;

  // stall/flush bit0 = ID/EX, bit1 = EX/MEM, bit2 = MEM/WB; flush beats stall.
  modport master (
    output op, funct, stall, flush,
    input  branch_d, jump_d, alu_ctrl_e, alu_src_e, reg_dst_e, mem_read_e,
           reg_write_e, mdu_e, reg_write_m, mem_write_m, mem_read_m,
           mem_to_reg_m, reg_write_w, mem_to_reg_w, mdu_busy, mdu_done,
           mdu_state
  );

  modport slave (
    input  op, funct, stall, flush,
    output branch_d, jump_d, alu_ctrl_e, alu_src_e, reg_dst_e, mem_read_e,
           reg_write_e, mdu_e, reg_write_m, mem_write_m, mem_read_m,
           mem_to_reg_m, reg_write_w, mem_to_reg_w, mdu_busy, mdu_done,
           mdu_state
  );

endinterface

// File: rtl/ctrl_decode.sv
// ID-stage main decoder: op/funct to the ID/EX control bundle plus branch/jump.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output id_ex_t     ctrl,
  output logic       branch,
  output logic       jump
);

  always_comb begin
    ctrl          = '0;
    ctrl.alu_ctrl = ALU_ADD;
    branch        = 1'b0;
    jump          = 1'b0;
    case (op)
      OP_RTYPE: begin
        // Unknown funct falls through as a NOP bundle.
        case (funct)
          FN_ADD: begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; end
          FN_SUB: begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_ctrl = ALU_SUB; end
          FN_AND: begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_ctrl = ALU_AND; end
          FN_OR:  begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_ctrl = ALU_OR;  end
          FN_SLT: begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_ctrl = ALU_SLT; end
          FN_MULT, FN_DIV: begin ctrl.reg_dst = 1'b1; ctrl.mdu = 1'b1; end
          default: ;
        endcase
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        branch        = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_J: jump = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_mdu.sv
// Pipelined control unit: ID/EX, EX/MEM, MEM/WB control registers with per-boundary
// stall/flush, and the MULT/DIV occupancy FSM that drives mdu_busy/mdu_done.
module ctrl_pipe_mdu
  import ctrl_pkg::*;
#(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = $clog2(MDU_LAT)
) (
  input logic           clk,
  input logic           rst,
  ctrl_pipe_mdu_if.slave bus
);

  // The IDLE entry cycle and the DONE cycle each account for one EX cycle, so
  // BUSY lasts MDU_LAT-2 cycles and the counter runs from MDU_LAT-3 down to 0.
  localparam logic [CNT_W-1:0] CNT_LOAD = (MDU_LAT > 2) ? CNT_W'(MDU_LAT - 3) : '0;

  id_ex_t     ctrl_d;
  id_ex_t     id_ex;
  ex_mem_t    ex_mem;
  mem_wb_t    mem_wb;
  mdu_state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  ctrl_decode u_decode (
    .op     (bus.op),
    .funct  (bus.funct),
    .ctrl   (ctrl_d),
    .branch (bus.branch_d),
    .jump   (bus.jump_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               id_ex <= '0;
    else if (bus.flush[0]) id_ex <= '0;
    else if (!bus.stall[0]) id_ex <= ctrl_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               ex_mem <= '0;
    else if (bus.flush[1]) ex_mem <= '0;
    else if (!bus.stall[1])
      ex_mem <= '{reg_write: id_ex.reg_write, mem_write: id_ex.mem_write,
                  mem_to_reg: id_ex.mem_to_reg, mem_read: id_ex.mem_read};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               mem_wb <= '0;
    else if (bus.flush[2]) mem_wb <= '0;
    else if (!bus.stall[2])
      mem_wb <= '{reg_write: ex_mem.reg_write, mem_to_reg: ex_mem.mem_to_reg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      MDU_IDLE: begin
        if (id_ex.mdu) begin
          state_nx = (MDU_LAT > 2) ? MDU_BUSY : MDU_DONE;
          cnt_nx   = CNT_LOAD;
        end
      end
      MDU_BUSY: begin
        if (cnt == '0) state_nx = MDU_DONE;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
      // mdu_e is still set here; leaving via IDLE stops a retrigger on the same op.
      MDU_DONE: if (!bus.stall[0]) state_nx = MDU_IDLE;
      default:  state_nx = MDU_IDLE;
    endcase
    if (bus.flush[0]) state_nx = MDU_IDLE;
  end

  assign bus.mdu_busy     = (state == MDU_BUSY) || ((state == MDU_IDLE) && id_ex.mdu);
  assign bus.mdu_done     = (state == MDU_DONE);
  assign bus.mdu_state    = state;

  assign bus.alu_ctrl_e   = id_ex.alu_ctrl;
  assign bus.alu_src_e    = id_ex.alu_src;
  assign bus.reg_dst_e    = id_ex.reg_dst;
  assign bus.mem_read_e   = id_ex.mem_read;
  assign bus.reg_write_e  = id_ex.reg_write;
  assign bus.mdu_e        = id_ex.mdu;
  assign bus.reg_write_m  = ex_mem.reg_write;
  assign bus.mem_write_m  = ex_mem.mem_write;
  assign bus.mem_read_m   = ex_mem.mem_read;
  assign bus.mem_to_reg_m = ex_mem.mem_to_reg;
  assign bus.reg_write_w  = mem_wb.reg_write;
  assign bus.mem_to_reg_w = mem_wb.mem_to_reg;

endmodule

// File: tb/tb_ctrl_pipe_mdu.sv
// Directed bench for ctrl_pipe_mdu with MDU_LAT = 4; inputs change and outputs
// are sampled on the falling edge.
module tb_ctrl_pipe_mdu;
  import ctrl_pkg::*;

  localparam int LAT = 4;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   cyc;
  logic [31:0] exp_q[$];

  ctrl_pipe_mdu_if bus ();

  ctrl_pipe_mdu #(.MDU_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // EX view: {alu_ctrl, alu_src, reg_dst, mem_read, reg_write, mdu}
  logic [7:0] ex_vec;
  // MEM view: {reg_write, mem_write, mem_read, mem_to_reg}
  logic [3:0] m_vec;
  logic [1:0] w_vec;
  assign ex_vec = {bus.alu_ctrl_e, bus.alu_src_e, bus.reg_dst_e, bus.mem_read_e,
                   bus.reg_write_e, bus.mdu_e};
  assign m_vec  = {bus.reg_write_m, bus.mem_write_m, bus.mem_read_m, bus.mem_to_reg_m};
  assign w_vec  = {bus.reg_write_w, bus.mem_to_reg_w};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] o, input logic [5:0] f,
                       input logic [2:0] s, input logic [2:0] fl);
    bus.op    = o;
    bus.funct = f;
    bus.stall = s;
    bus.flush = fl;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Issues one MULT/DIV and acts as the hazard unit (stall[0] = mdu_busy).
  task automatic run_mdu(input string tag, input logic [5:0] fn);
    drive(OP_RTYPE, fn, 3'b000, 3'b000);
    tick();
    for (int k = 0; k <= LAT; k++) begin
      check({tag, "_busy"}, 32'(bus.mdu_busy), 32'(k <= LAT - 2));
      check({tag, "_done"}, 32'(bus.mdu_done), 32'(k == LAT - 1));
      drive(OP_RTYPE, 6'b000000, {2'b00, bus.mdu_busy}, 3'b000);
      tick();
    end
    check({tag, "_idle"}, 32'(bus.mdu_state), 32'(MDU_IDLE));
  endtask

  initial begin
    int n_done;
    int c0;
    logic use_mult;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst      = 1'b1;
    drive(OP_J, 6'b000000, 3'b000, 3'b000);
    tick();
    tick();

    // reset state; ID decode stays live
    check("rst_ex", 32'(ex_vec), 32'h0);
    check("rst_m", 32'(m_vec), 32'h0);
    check("rst_w", 32'(w_vec), 32'h0);
    check("rst_busy", 32'(bus.mdu_busy), 32'h0);
    check("rst_done", 32'(bus.mdu_done), 32'h0);
    check("rst_jump_d", 32'(bus.jump_d), 32'h1);
    check("rst_branch_d", 32'(bus.branch_d), 32'h0);
    rst = 1'b0;

    // lw through all stages
    drive(OP_LW, 6'b000000, 3'b000, 3'b000);
    tick();
    check("lw_ex", 32'(ex_vec), 32'(8'b010_1_0_1_1_0));
    check("lw_m_pre", 32'(m_vec), 32'h0);
    drive(OP_RTYPE, 6'b000000, 3'b000, 3'b000);
    tick();
    check("lw_m", 32'(m_vec), 32'(4'b1011));
    check("nop_ex", 32'(ex_vec), 32'(8'b010_0_0_0_0_0));
    tick();
    check("lw_w", 32'(w_vec), 32'(2'b11));

    // beq / j decode and beq EX bundle
    drive(OP_BEQ, 6'b000000, 3'b000, 3'b000);
    #1;
    check("beq_branch_d", 32'(bus.branch_d), 32'h1);
    check("beq_jump_d", 32'(bus.jump_d), 32'h0);
    tick();
    check("beq_ex", 32'(ex_vec), 32'(8'b110_0_0_0_0_0));
    drive(OP_J, 6'b000000, 3'b000, 3'b000);
    #1;
    check("j_jump_d", 32'(bus.jump_d), 32'h1);
    tick();
    check("j_ex", 32'(ex_vec), 32'(8'b010_0_0_0_0_0));

    // sw reaches MEM with mem_write
    drive(OP_SW, 6'b000000, 3'b000, 3'b000);
    tick();
    check("sw_ex", 32'(ex_vec), 32'(8'b010_1_0_0_0_0));
    drive(OP_RTYPE, 6'b000000, 3'b000, 3'b000);
    tick();
    check("sw_m", 32'(m_vec), 32'(4'b0100));

    // flush beats stall on ID/EX; stall alone holds
    drive(OP_RTYPE, FN_ADD, 3'b000, 3'b000);
    tick();
    check("add_ex", 32'(ex_vec), 32'(8'b010_0_1_0_1_0));
    drive(OP_RTYPE, FN_SUB, 3'b001, 3'b001);
    tick();
    check("sub_flush_ex", 32'(ex_vec), 32'h0);
    drive(OP_RTYPE, FN_ADD, 3'b000, 3'b000);
    tick();
    drive(OP_RTYPE, FN_SUB, 3'b001, 3'b000);
    tick();
    check("sub_stall_hold", 32'(ex_vec), 32'(8'b010_0_1_0_1_0));
    drive(OP_RTYPE, FN_SUB, 3'b000, 3'b000);
    tick();
    check("sub_ex", 32'(ex_vec), 32'(8'b110_0_1_0_1_0));
    drive(OP_RTYPE, FN_SLT, 3'b000, 3'b000);
    tick();
    check("slt_ex", 32'(ex_vec), 32'(8'b111_0_1_0_1_0));
    drive(OP_RTYPE, FN_OR, 3'b000, 3'b000);
    tick();
    check("or_ex", 32'(ex_vec), 32'(8'b001_0_1_0_1_0));
    drive(OP_RTYPE, FN_AND, 3'b000, 3'b000);
    tick();
    check("and_ex", 32'(ex_vec), 32'(8'b000_0_1_0_1_0));
    drive(OP_ADDI, 6'b000000, 3'b000, 3'b000);
    tick();
    check("addi_ex", 32'(ex_vec), 32'(8'b010_1_0_0_1_0));
    drive(OP_BAD, FN_ADD, 3'b000, 3'b000);
    tick();
    check("badop_ex", 32'(ex_vec), 32'(8'b010_0_0_0_0_0));
    drive(OP_RTYPE, 6'b000001, 3'b000, 3'b000);
    tick();
    check("badfn_ex", 32'(ex_vec), 32'(8'b010_0_0_0_0_0));

    // EX/MEM stall and MEM/WB flush
    drive(OP_LW, 6'b000000, 3'b000, 3'b000);
    tick();
    drive(OP_RTYPE, 6'b000000, 3'b000, 3'b000);
    tick();
    drive(OP_RTYPE, 6'b000000, 3'b010, 3'b000);
    tick();
    check("exmem_stall_m", 32'(m_vec), 32'(4'b1011));
    check("exmem_stall_w", 32'(w_vec), 32'(2'b11));
    drive(OP_RTYPE, 6'b000000, 3'b000, 3'b100);
    tick();
    check("memwb_flush_w", 32'(w_vec), 32'h0);
    check("memwb_flush_m", 32'(m_vec), 32'h0);
    drive(OP_RTYPE, 6'b000000, 3'b000, 3'b000);
    tick();

    // single mult, then div
    run_mdu("mult", FN_MULT);
    run_mdu("div", FN_DIV);

    // DONE held while EX is stalled
    drive(OP_RTYPE, FN_MULT, 3'b000, 3'b000);
    tick();
    for (int k = 0; k < LAT - 1; k++) begin
      drive(OP_RTYPE, 6'b000000, 3'b001, 3'b000);
      tick();
    end
    check("hold_done0", 32'(bus.mdu_done), 32'h1);
    tick();
    check("hold_done1", 32'(bus.mdu_done), 32'h1);
    check("hold_busy", 32'(bus.mdu_busy), 32'h0);
    drive(OP_RTYPE, 6'b000000, 3'b000, 3'b000);
    tick();
    check("hold_release", 32'(bus.mdu_state), 32'(MDU_IDLE));
    check("hold_release_done", 32'(bus.mdu_done), 32'h0);

    // flush[0] aborts a mult in BUSY
    drive(OP_RTYPE, FN_MULT, 3'b000, 3'b000);
    tick();
    check("abort_busy_t", 32'(bus.mdu_busy), 32'h1);
    drive(OP_RTYPE, 6'b000000, 3'b001, 3'b000);
    tick();
    check("abort_state_t1", 32'(bus.mdu_state), 32'(MDU_BUSY));
    drive(OP_RTYPE, 6'b000000, 3'b001, 3'b001);
    tick();
    check("abort_busy_t2", 32'(bus.mdu_busy), 32'h0);
    check("abort_state_t2", 32'(bus.mdu_state), 32'(MDU_IDLE));
    drive(OP_RTYPE, 6'b000000, 3'b000, 3'b000);
    n_done = 0;
    for (int k = 0; k < 2 * LAT; k++) begin
      tick();
      if (bus.mdu_done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'h0);

    // async reset in the middle of a div
    drive(OP_RTYPE, FN_DIV, 3'b000, 3'b000);
    tick();
    drive(OP_RTYPE, 6'b000000, 3'b001, 3'b000);
    tick();
    check("arst_pre_state", 32'(bus.mdu_state), 32'(MDU_BUSY));
    #2 rst = 1'b1;
    #1;
    check("arst_state", 32'(bus.mdu_state), 32'(MDU_IDLE));
    check("arst_busy", 32'(bus.mdu_busy), 32'h0);
    check("arst_done", 32'(bus.mdu_done), 32'h0);
    check("arst_ex", 32'(ex_vec), 32'h0);
    check("arst_mw", 32'({m_vec, w_vec}), 32'h0);
    drive(OP_RTYPE, 6'b000000, 3'b000, 3'b000);
    tick();
    rst = 1'b0;
    run_mdu("post_rst", FN_MULT);

    // back-to-back mults: two done pulses LAT cycles apart
    drive(OP_RTYPE, FN_MULT, 3'b000, 3'b000);
    tick();
    c0 = cyc;
    exp_q.push_back(32'(c0 + LAT - 1));
    exp_q.push_back(32'(c0 + 2 * LAT - 1));
    n_done = 0;
    for (int k = 0; k < 3 * LAT; k++) begin
      if (bus.mdu_done) begin
        n_done++;
        if (exp_q.size() == 0) check("b2b_extra_done", 32'(cyc), 32'hffff_ffff);
        else                   check("b2b_done_cycle", 32'(cyc), exp_q.pop_front());
      end
      use_mult = (n_done == 0) || (bus.mdu_done && n_done == 1);
      drive(OP_RTYPE, use_mult ? FN_MULT : 6'b000000, {2'b00, bus.mdu_busy}, 3'b000);
      tick();
    end
    check("b2b_count", 32'(n_done), 32'd2);
    check("b2b_missing", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
